// File: rtl/xc_malu_divrem_result_pkg.sv
// Shared definitions for the MALU divide/remainder result stage.
package xc_malu_divrem_result_pkg;

  localparam int unsigned XC_XLEN = 32;

  localparam logic [XC_XLEN-1:0] XC_DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XC_XLEN-1:0] XC_INT_MIN    = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIX  = 2'd1,
    ST_HOLD = 2'd2
  } xc_divrem_state_e;

endpackage

// File: rtl/xc_malu_negate.sv
// Conditional two's complement negation (modulo 2^W), purely combinational.
module xc_malu_negate #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = neg_i ? (~a_i + W'(1)) : a_i;
  end

endmodule

// File: rtl/xc_malu_divrem_result.sv
// Result stage behind the multi-cycle divider: sign fix-up, RISC-V special
// cases, DIV/REM select, and a valid/ready hold towards writeback.
module xc_malu_divrem_result
  import xc_malu_divrem_result_pkg::*;
#(
  parameter int unsigned XLEN = XC_XLEN
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            flush,
  input  logic            div_done,
  input  logic [XLEN-1:0] div_quot,
  input  logic [XLEN-1:0] div_rem,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            op_signed,
  input  logic            op_rem,
  output logic            div_clear,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  xc_divrem_state_e state_q;
  logic             was_fix_q;
  logic [XLEN-1:0]  quot_q, rem_q, rs1_q;
  logic             zdiv_q, ovf_q, nq_q, nr_q, op_rem_q;
  logic             div_clear_q, out_valid_q;
  logic [XLEN-1:0]  out_result_q;

  logic [XLEN-1:0]  neg_in_c, neg_out_c, fix_result_c;
  logic             neg_en_c;

  // One negator shared between quotient and remainder paths.
  always_comb begin
    neg_in_c = op_rem_q ? rem_q : quot_q;
    neg_en_c = op_rem_q ? nr_q  : nq_q;
  end

  xc_malu_negate #(.W(XLEN)) u_negate (
    .a_i   (neg_in_c),
    .neg_i (neg_en_c),
    .y_o   (neg_out_c)
  );

  always_comb begin
    fix_result_c = neg_out_c;
    if (zdiv_q) begin
      fix_result_c = op_rem_q ? rs1_q : XC_DIV_ZERO_Q;
    end else if (ovf_q) begin
      fix_result_c = op_rem_q ? '0 : XC_INT_MIN;
    end
  end

  // was_fix_q survives flush so a done still high right after an aborted FIX
  // is not mistaken for a fresh result.
  always_ff @(posedge clock) begin
    if (!resetn || flush) begin
      state_q      <= ST_IDLE;
      was_fix_q    <= resetn && (state_q == ST_FIX);
      div_clear_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else begin
      was_fix_q   <= (state_q == ST_FIX);
      div_clear_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (div_done && !was_fix_q) begin
            quot_q      <= div_quot;
            rem_q       <= div_rem;
            rs1_q       <= rs1;
            zdiv_q      <= (rs2 == '0);
            ovf_q       <= op_signed && (rs1 == XC_INT_MIN) && (rs2 == XC_DIV_ZERO_Q);
            nq_q        <= op_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
            nr_q        <= op_signed && rs1[XLEN-1];
            op_rem_q    <= op_rem;
            div_clear_q <= 1'b1;
            state_q     <= ST_FIX;
          end
        end
        ST_FIX: begin
          out_result_q <= fix_result_c;
          out_valid_q  <= 1'b1;
          state_q      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign div_clear  = div_clear_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

endmodule
